// File: rtl/tc_timer.sv
`timescale 1ns/1ps
// tc_timer: memory-mapped down-counting timer with a level interrupt.
// Ports:
//   clk   - system clock, all state changes on the rising edge
//   reset - synchronous, active-high reset
//   Addr  - word address from the bridge; only Addr[1:0] is decoded
//   WE    - full-word write strobe for this device
//   Din   - write data
//   Dout  - combinational read data for Addr
//   IRQ   - interrupt request, irq flag gated by CTRL.IM
// Register map (Addr[1:0]):
//   0 CTRL   {IM, Mode[1:0], En}, upper bits read as 0
//   1 PRESET reload value
//   2 COUNT  current count, read-only
//   3 reserved, reads 0
module tc_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;

    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic        wr_ctrl;
    logic        wr_preset;

    // Only the low two word-address bits select a register.
    logic        unused_addr;
    assign unused_addr = ^Addr[29:2];

    assign ctrl_en   = ctrl_q[0];
    assign ctrl_mode = ctrl_q[2:1];
    assign ctrl_im   = ctrl_q[3];

    assign wr_ctrl   = WE && (Addr[1:0] == A_CTRL);
    assign wr_preset = WE && (Addr[1:0] == A_PRESET);

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        unique case (state_q)
            S_IDLE: begin
                if (ctrl_en) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_en) begin
                    // Pause: COUNT keeps its value until the next LOAD.
                    state_d = S_IDLE;
                end else if (count_q != 32'd0) begin
                    count_d = count_q - 32'd1;
                end else begin
                    state_d = S_INT;
                    flag_d  = 1'b1;
                end
            end
            S_INT: begin
                if (ctrl_mode == 2'b00) begin
                    // One-shot: stop and leave the flag for software.
                    ctrl_d[0] = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    // Auto-reload goes straight to LOAD so that the
                    // period is PRESET+3 cycles.
                    flag_d  = 1'b0;
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bus writes override the FSM's own updates on the same edge.
        if (wr_ctrl) begin
            ctrl_d = Din[3:0];
        end
        if (wr_preset) begin
            preset_d = Din;
        end
        if (wr_ctrl || wr_preset) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        Dout = 32'd0;
        unique case (Addr[1:0])
            A_CTRL:   Dout = {28'd0, ctrl_q};
            A_PRESET: Dout = preset_q;
            A_COUNT:  Dout = count_q;
            default:  Dout = 32'd0;
        endcase
    end

    assign IRQ = flag_q & ctrl_im;

endmodule

// File: tb/tb_tc_timer.sv
`timescale 1ns/1ps
// tb_tc_timer: register table, directed timing sequences and a
// randomized run against an elapsed-time reference model.
module tb_tc_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [29:0] Addr = '0;
    logic        WE = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        IRQ;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tc_timer dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    // Reference model. A run is described by the number of edges
    // since it left IDLE (m_t=1 is the LOAD edge); COUNT follows
    // from the captured PRESET by plain arithmetic.
    bit          m_run;
    longint      m_t;
    longint      m_snap;
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    bit          m_flag;

    task automatic m_step(input bit r, input bit we, input int a,
                          input logic [31:0] d);
        bit          n_run;
        longint      n_t;
        longint      n_snap;
        logic [3:0]  n_ctrl;
        logic [31:0] n_preset;
        logic [31:0] n_count;
        bit          n_flag;
        bit          en;
        bit          reload;
        if (r) begin
            m_run = 0; m_t = 0; m_snap = 0;
            m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 0;
            return;
        end
        n_run = m_run; n_t = m_t; n_snap = m_snap;
        n_ctrl = m_ctrl; n_preset = m_preset;
        n_count = m_count; n_flag = m_flag;
        en = m_ctrl[0];
        reload = (m_ctrl[2:1] != 2'b00);
        if (!m_run) begin
            if (en) begin
                n_run = 1; n_t = 1;
            end
        end else if (m_t == 1) begin
            n_snap = longint'(m_preset);
            n_count = m_preset;
            n_t = 2;
        end else if (m_t < m_snap + 3) begin
            if (!en) begin
                n_run = 0;
            end else begin
                n_t = m_t + 1;
                if (n_t == m_snap + 3) n_flag = 1;
                else n_count = 32'(m_snap - (n_t - 2));
            end
        end else begin
            if (!reload) begin
                n_run = 0; n_ctrl[0] = 1'b0;
            end else begin
                n_flag = 0; n_t = 1;
            end
        end
        if (we && a == 0) n_ctrl = d[3:0];
        if (we && a == 1) n_preset = d;
        if (we && (a == 0 || a == 1)) n_flag = 0;
        m_run = n_run; m_t = n_t; m_snap = n_snap;
        m_ctrl = n_ctrl; m_preset = n_preset;
        m_count = n_count; m_flag = n_flag;
    endtask

    function automatic logic [31:0] m_dout(input int a);
        case (a)
            0: return {28'd0, m_ctrl};
            1: return m_preset;
            2: return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     name, act, exp);
        end
    endtask

    task automatic rd(input int a, output logic [31:0] v);
        Addr = 30'(a);
        #1;
        v = Dout;
    endtask

    task automatic chk_rd(input string name, input int a,
                          input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        chk(name, v, exp);
    endtask

    task automatic chk_irq(input string name, input bit exp);
        chk(name, 32'(IRQ), 32'(exp));
    endtask

    task automatic cyc(input bit r, input bit we, input int a,
                       input logic [31:0] d);
        reset = r; WE = we; Addr = 30'(a); Din = d;
        @(posedge clk);
        m_step(r, we, a, d);
        #1;
        reset = 1'b0; WE = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cyc(0, 1, a, d);
    endtask

    task automatic nop();
        cyc(0, 0, 0, 32'd0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 32'd0);
        cyc(1, 0, 0, 32'd0);
    endtask

    typedef struct {
        bit          we;
        int          wa;
        logic [31:0] wd;
        int          ra;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [31:0] v;

        tbl[0] = '{1'b1, 1, 32'h1234_5678, 1, 32'h1234_5678, "preset_rw"};
        tbl[1] = '{1'b1, 2, 32'h0000_0055, 2, 32'h0, "count_ro"};
        tbl[2] = '{1'b1, 0, 32'hFFFF_FFF0, 0, 32'h0, "ctrl_resv"};
        tbl[3] = '{1'b1, 3, 32'hDEAD_BEEF, 3, 32'h0, "addr3_rd"};
        tbl[4] = '{1'b1, 0, 32'h0000_0006, 0, 32'h6, "ctrl_mode"};
        tbl[5] = '{1'b1, 0, 32'hFFFF_FFFE, 0, 32'hE, "ctrl_mask"};
        tbl[6] = '{1'b0, 0, 32'h0, 1, 32'h1234_5678, "preset_hold"};
        tbl[7] = '{1'b1, 0, 32'h0, 0, 32'h0, "ctrl_clr"};
        tbl[8] = '{1'b1, 1, 32'h0, 1, 32'h0, "preset_clr"};

        // Reset state
        do_reset();
        for (int k = 0; k < 4; k++)
            chk_rd($sformatf("reset_rd%0d", k), k, 32'd0);
        chk_irq("reset_irq", 0);

        // Register access table (En stays 0 throughout)
        foreach (tbl[i]) begin
            cyc(0, tbl[i].we, tbl[i].wa, tbl[i].wd);
            chk_rd(tbl[i].name, tbl[i].ra, tbl[i].exp);
        end

        // Reset asserted mid-count, together with a write
        do_reset();
        wr(1, 5); wr(0, 9);
        nop(); nop(); nop();
        cyc(1, 1, 1, 32'd7);
        for (int k = 0; k < 4; k++)
            chk_rd($sformatf("midrst_rd%0d", k), k, 32'd0);
        chk_irq("midrst_irq", 0);
        nop();
        chk_rd("midrst_idle_cnt", 2, 32'd0);

        // Mode 0 one-shot, PRESET=3
        do_reset();
        wr(1, 3); wr(0, 9);
        nop(); nop();
        chk_rd("m0_cnt_e2", 2, 3);
        nop(); chk_rd("m0_cnt_e3", 2, 2);
        nop(); chk_rd("m0_cnt_e4", 2, 1);
        nop(); chk_rd("m0_cnt_e5", 2, 0);
        chk_irq("m0_irq_e5", 0);
        nop(); chk_irq("m0_irq_e6", 1);
        chk_rd("m0_ctrl_e6", 0, 32'h9);
        nop(); chk_rd("m0_ctrl_e7", 0, 32'h8);
        for (int k = 0; k < 20; k++) begin
            nop();
            chk_irq($sformatf("m0_hold%0d", k), 1);
        end
        chk_rd("m0_cnt_hold", 2, 0);
        wr(0, 8);
        chk_irq("m0_irq_clr", 0);

        // Mode 1 periodic, PRESET=2
        do_reset();
        wr(1, 2); wr(0, 32'hB);
        for (int k = 1; k <= 16; k++) begin
            nop();
            chk_irq($sformatf("m1_irq_e%0d", k),
                    (k == 5 || k == 10 || k == 15));
            if (k == 7 || k == 12)
                chk_rd($sformatf("m1_reload_e%0d", k), 2, 2);
        end

        // Pause / resume, PRESET=10
        do_reset();
        wr(1, 10); wr(0, 9);
        nop(); nop();
        chk_rd("pr_cnt_e2", 2, 10);
        nop(); nop(); nop();
        chk_rd("pr_cnt_e5", 2, 7);
        wr(0, 8);
        chk_rd("pr_cnt_e6", 2, 6);
        nop();
        chk_rd("pr_cnt_e7", 2, 6);
        wr(2, 32'h55);
        chk_rd("pr_cnt_wr", 2, 6);
        for (int k = 0; k < 4; k++) begin
            nop();
            chk_rd($sformatf("pr_hold%0d", k), 2, 6);
            chk_irq($sformatf("pr_irq%0d", k), 0);
        end
        wr(0, 9);
        nop();
        chk_rd("pr_cnt_r1", 2, 6);
        nop();
        chk_rd("pr_cnt_r2", 2, 10);
        wr(0, 0);

        // PRESET write mid-count
        do_reset();
        wr(1, 4); wr(0, 32'hB);
        nop(); nop();
        chk_rd("pw_cnt_e2", 2, 4);
        wr(1, 1);
        chk_rd("pw_cnt_e3", 2, 3);
        nop(); chk_rd("pw_cnt_e4", 2, 2);
        nop(); chk_rd("pw_cnt_e5", 2, 1);
        nop(); chk_rd("pw_cnt_e6", 2, 0);
        nop(); chk_irq("pw_irq_e7", 1);
        nop(); chk_irq("pw_irq_e8", 0);
        nop(); chk_rd("pw_cnt_e9", 2, 1);
        wr(0, 0);

        // CTRL write on the INT edge
        do_reset();
        wr(0, 9);
        nop(); nop(); nop();
        chk_irq("ci_irq_e3", 1);
        wr(0, 5);
        chk_rd("ci_ctrl_e4", 0, 32'h5);
        chk_irq("ci_irq_e4", 0);
        wr(0, 0);

        // IM masking
        do_reset();
        wr(1, 1); wr(0, 1);
        for (int k = 1; k <= 8; k++) begin
            nop();
            chk_irq($sformatf("im_irq_e%0d", k), 0);
        end
        chk_rd("im_ctrl_done", 0, 32'h0);
        wr(0, 8);
        for (int k = 0; k < 3; k++) begin
            nop();
            chk_irq($sformatf("im_irq_clr%0d", k), 0);
        end
        chk_rd("im_ctrl_8", 0, 32'h8);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          we;
            int          a;
            logic [31:0] d;
            r  = ($urandom_range(0, 299) == 0);
            we = ($urandom_range(0, 9) == 0);
            a  = int'($urandom_range(0, 3));
            d  = $urandom;
            if (a == 1)
                d = $urandom_range(0, 6);
            else if (a == 0 && $urandom_range(0, 3) != 0)
                d[0] = 1'b1;
            cyc(r, we, a, d);
            for (int k = 0; k < 4; k++) begin
                rd(k, v);
                chk($sformatf("rand%0d_rd%0d", i, k), v, m_dout(k));
            end
            chk_irq($sformatf("rand%0d_irq", i), m_flag & m_ctrl[3]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
